// File: rtl/ram_bus_arbiter_pkg.sv
// rtl/ram_bus_arbiter_pkg.sv - shared widths, mem op codes, arbiter state codes and grant helper
package ram_bus_arbiter_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LH  = 4'd1;
  localparam logic [3:0] OP_LW  = 4'd2;
  localparam logic [3:0] OP_LBU = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_SB  = 4'd5;
  localparam logic [3:0] OP_SH  = 4'd6;
  localparam logic [3:0] OP_SW  = 4'd7;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT_D = 2'd1,
    ARB_GRANT_I = 2'd2
  } arb_state_e;

  typedef enum logic {
    SIDE_INST = 1'b0,
    SIDE_DATA = 1'b1
  } side_e;

  // With both requesters pending, the side that did not win last time goes next.
  function automatic side_e arb_pick(input logic i_pend, input logic d_pend, input side_e last);
    if (d_pend && !i_pend) return SIDE_DATA;
    if (i_pend && !d_pend) return SIDE_INST;
    return (last == SIDE_INST) ? SIDE_DATA : SIDE_INST;
  endfunction
endpackage

// File: rtl/ram_bus_arbiter_if.sv
// rtl/ram_bus_arbiter_if.sv - fetch, data and RAM port signals shared by the arbiter and its environment
interface ram_bus_arbiter_if;
  import ram_bus_arbiter_pkg::*;

  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_ack;
  logic [DATA_WIDTH-1:0] i_rdata;
  logic                  i_err;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [3:0]            d_op;
  logic                  d_ack;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_err;
  logic                  stall;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_op;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_op, mem_ack, mem_rdata,
    output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err, stall,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_op
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_op, mem_ack, mem_rdata,
    input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err, stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_op
  );
endinterface

// File: rtl/ram_bus_arbiter_timeout.sv
// rtl/ram_bus_arbiter_timeout.sv - per-grant watchdog counter, expires at TIMEOUT_CYCLES-1
module bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = (cnt == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/ram_bus_arbiter.sv
// rtl/ram_bus_arbiter.sv - round-robin sharing of one RAM port between fetch and data access
module ram_bus_arbiter
  import ram_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic              clk,
  input logic              rst,
  ram_bus_arbiter_if.slave bus
);
  arb_state_e state;
  side_e      last_grant;
  logic       grant_d;
  logic       grant_i;
  logic       in_grant;
  logic       expire;
  logic       acked;
  logic       timed_out;
  logic       start_d;
  logic       start_i;

  assign grant_d   = (state == ARB_GRANT_D);
  assign grant_i   = (state == ARB_GRANT_I);
  assign in_grant  = grant_d | grant_i;
  assign acked     = in_grant & bus.mem_ack;
  // An ack landing on the expiry cycle completes normally.
  assign timed_out = in_grant & expire & ~bus.mem_ack;

  assign bus.i_ack   = grant_i & bus.mem_ack;
  assign bus.d_ack   = grant_d & bus.mem_ack;
  assign bus.i_err   = grant_i & timed_out;
  assign bus.d_err   = grant_d & timed_out;
  assign bus.i_rdata = bus.i_ack ? bus.mem_rdata : '0;
  assign bus.d_rdata = bus.d_ack ? bus.mem_rdata : '0;
  assign bus.stall   = bus.d_req & ~bus.d_ack & ~bus.d_err;

  // After an ack only the other requester is considered, so the finished one never re-wins on a stale req.
  always_comb begin
    start_d = 1'b0;
    start_i = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (bus.i_req || bus.d_req) begin
          if (arb_pick(bus.i_req, bus.d_req, last_grant) == SIDE_DATA) start_d = 1'b1;
          else start_i = 1'b1;
        end
      end
      ARB_GRANT_D: start_i = bus.mem_ack & bus.i_req;
      ARB_GRANT_I: start_d = bus.mem_ack & bus.d_req;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ARB_IDLE;
      last_grant    <= SIDE_INST;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_op    <= '0;
    end else if (start_d) begin
      state         <= ARB_GRANT_D;
      last_grant    <= SIDE_DATA;
      bus.mem_req   <= 1'b1;
      bus.mem_we    <= bus.d_we;
      bus.mem_addr  <= bus.d_addr;
      bus.mem_wdata <= bus.d_wdata;
      bus.mem_op    <= bus.d_op;
    end else if (start_i) begin
      state         <= ARB_GRANT_I;
      last_grant    <= SIDE_INST;
      bus.mem_req   <= 1'b1;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= bus.i_addr;
      bus.mem_wdata <= '0;
      bus.mem_op    <= OP_LW;
    end else if (acked || timed_out) begin
      state         <= ARB_IDLE;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_op    <= '0;
    end
  end

  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (start_d | start_i | ~in_grant),
    .enable (in_grant),
    .expire (expire)
  );
endmodule

// File: tb/tb_ram_bus_arbiter.sv
// tb/tb_ram_bus_arbiter.sv - scoreboard bench for ram_bus_arbiter with directed and random traffic
module tb_ram_bus_arbiter;
  import ram_bus_arbiter_pkg::*;

  localparam int         TO   = 16;
  localparam logic [7:0] CH_D = 8'h44;
  localparam logic [7:0] CH_I = 8'h49;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  exp_t        i_exp[$];
  exp_t        d_exp[$];
  logic [7:0]  ack_log[$];
  logic [31:0] model_mem[logic [31:0]];
  logic [31:0] ram_mem[logic [31:0]];

  int ram_lat  = 1;
  bit ram_hang = 1'b0;
  bit ram_rand = 1'b0;
  int inj_req  = 0;

  always #5 clk = ~clk;

  ram_bus_arbiter_if bus();

  ram_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: no response within cycle budget, expected one", name);
  endtask

  function automatic logic [31:0] gen(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return gen(a);
  endfunction

  // RAM: word memory answering each new transaction after ram_lat cycles
  initial begin
    int wait_left;
    bit in_txn;
    int inj_done;
    wait_left = 0;
    in_txn    = 1'b0;
    inj_done  = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      if (inj_req != inj_done) begin
        inj_done      = inj_req;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hBAD0_0001;
      end else if (!bus.mem_req || rst) begin
        in_txn = 1'b0;
      end else if (!ram_hang) begin
        if (!in_txn) begin
          in_txn    = 1'b1;
          wait_left = ram_rand ? int'($urandom_range(0, 4)) : ram_lat;
        end
        if (wait_left == 0) begin
          in_txn      = 1'b0;
          bus.mem_ack = 1'b1;
          if (bus.mem_we) ram_mem[bus.mem_addr] = bus.mem_wdata;
          else bus.mem_rdata = ram_mem.exists(bus.mem_addr) ? ram_mem[bus.mem_addr] : gen(bus.mem_addr);
        end else begin
          wait_left--;
        end
      end
    end
  end

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!bus.i_ack) check("i_rdata_zero", bus.i_rdata, 32'h0);
      if (!bus.d_ack) check("d_rdata_zero", bus.d_rdata, 32'h0);
      if (bus.i_ack || bus.i_err) begin
        if (i_exp.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL i_unexpected: ack=%0b err=%0b, expected no fetch response", bus.i_ack, bus.i_err);
        end else begin
          e = i_exp.pop_front();
          check("i_err", 32'(bus.i_err), 32'(e.err));
          check("i_ack", 32'(bus.i_ack), 32'(!e.err));
          if (!e.err) check("i_rdata", bus.i_rdata, e.data);
        end
        if (bus.i_ack) ack_log.push_back(CH_I);
      end
      if (bus.d_ack || bus.d_err) begin
        if (d_exp.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL d_unexpected: ack=%0b err=%0b, expected no data response", bus.d_ack, bus.d_err);
        end else begin
          e = d_exp.pop_front();
          check("d_err", 32'(bus.d_err), 32'(e.err));
          check("d_ack", 32'(bus.d_ack), 32'(!e.err));
          if (!e.err) check("d_rdata", bus.d_rdata, e.data);
        end
        if (bus.d_ack) ack_log.push_back(CH_D);
      end
    end
  end

  task automatic do_fetch(input logic [31:0] a, input bit exp_err);
    exp_t e;
    int   n;
    e.err  = exp_err;
    e.data = exp_err ? 32'h0 : model_rd(a);
    i_exp.push_back(e);
    bus.i_req  = 1'b1;
    bus.i_addr = a;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.i_ack || bus.i_err) && n < 80);
    if (!(bus.i_ack || bus.i_err)) begin
      fail_now("fetch_wait");
      void'(i_exp.pop_back());
    end
    @(posedge clk);
    #1;
    bus.i_req = 1'b0;
  endtask

  task automatic do_data(input bit we, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input bit exp_err);
    exp_t e;
    int   n;
    e.err  = exp_err;
    e.data = (exp_err || we) ? 32'h0 : model_rd(a);
    if (we && !exp_err) model_mem[a] = wd;
    d_exp.push_back(e);
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_op    = op;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.d_ack || bus.d_err) && n < 80);
    if (!(bus.d_ack || bus.d_err)) begin
      fail_now("data_wait");
      void'(d_exp.pop_back());
    end
    @(posedge clk);
    #1;
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
  endtask

  initial begin
    int n;
    bus.i_req = 1'b0;  bus.i_addr  = '0;
    bus.d_req = 1'b0;  bus.d_we    = 1'b0;
    bus.d_addr = '0;   bus.d_wdata = '0;  bus.d_op = '0;
    rst = 1'b1;
    model_mem[32'h100] = 32'h0000_0013;
    ram_mem[32'h100]   = 32'h0000_0013;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req",   32'(bus.mem_req), 32'h0);
    check("rst_mem_we",    32'(bus.mem_we), 32'h0);
    check("rst_mem_addr",  bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_mem_op",    32'(bus.mem_op), 32'h0);
    check("rst_i_ack",     32'(bus.i_ack), 32'h0);
    check("rst_d_ack",     32'(bus.d_ack), 32'h0);
    check("rst_i_err",     32'(bus.i_err), 32'h0);
    check("rst_d_err",     32'(bus.d_err), 32'h0);
    check("rst_stall",     32'(bus.stall), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // fetch only, RAM latency 3
    ram_lat = 3;
    fork
      do_fetch(32'h100, 1'b0);
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        check("t1_stall", 32'(bus.stall), 32'h0);
        if (bus.mem_req) begin
          check("t1_op",   32'(bus.mem_op), 32'(OP_LW));
          check("t1_we",   32'(bus.mem_we), 32'h0);
          check("t1_addr", bus.mem_addr, 32'h100);
        end
      end
    join

    // simultaneous requests: data first, fetch follows with no idle cycle
    ram_lat = 1;
    ack_log.delete();
    fork
      do_data(1'b0, OP_LW, 32'h2004, 32'h0, 1'b0);
      do_fetch(32'h104, 1'b0);
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.d_ack && n < 40);
        if (!bus.d_ack) fail_now("t2_d_ack");
        else begin
          @(negedge clk);
          check("t2_no_bubble", 32'(bus.mem_req), 32'h1);
          check("t2_addr",      bus.mem_addr, 32'h104);
          check("t2_op",        32'(bus.mem_op), 32'(OP_LW));
          check("t2_we",        32'(bus.mem_we), 32'h0);
        end
      end
    join
    check("t2_ack_count", ack_log.size(), 32'd2);
    if (ack_log.size() == 2) begin
      check("t2_first",  32'(ack_log[0]), 32'(CH_D));
      check("t2_second", 32'(ack_log[1]), 32'(CH_I));
    end

    // both continuously pending: strict alternation
    ack_log.delete();
    fork
      begin
        logic [31:0] da;
        for (int k = 0; k < 4; k++) begin
          da = 32'h2000 + (32'(k) << 2);
          do_data(1'b0, OP_LW, da, 32'h0, 1'b0);
        end
      end
      begin
        logic [31:0] fa;
        repeat (4) begin
          fa = 32'($urandom_range(0, 1023)) << 2;
          do_fetch(fa, 1'b0);
        end
      end
    join
    check("t3_ack_count", ack_log.size(), 32'd8);
    if (ack_log.size() == 8) begin
      for (int k = 0; k < 8; k++)
        check($sformatf("t3_order_%0d", k), 32'(ack_log[k]), (k % 2 == 0) ? 32'(CH_D) : 32'(CH_I));
    end

    // store: fields stable, stall until ack cycle; then read back
    ram_lat = 3;
    fork
      do_data(1'b1, OP_SW, 32'h2000, 32'hDEAD_BEEF, 1'b0);
      begin
        bit done;
        done = 1'b0;
        n = 0;
        while (!done && n < 30) begin
          @(negedge clk);
          n++;
          if (bus.mem_req) begin
            check("t4_we",    32'(bus.mem_we), 32'h1);
            check("t4_op",    32'(bus.mem_op), 32'(OP_SW));
            check("t4_addr",  bus.mem_addr, 32'h2000);
            check("t4_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
          end
          if (bus.d_ack) begin
            check("t4_stall_ack", 32'(bus.stall), 32'h0);
            done = 1'b1;
          end else begin
            check("t4_stall", 32'(bus.stall), 32'h1);
          end
        end
        if (!done) fail_now("t4_d_ack");
      end
    join
    do_data(1'b0, OP_LW, 32'h2000, 32'h0, 1'b0);

    // hung RAM: data times out, pending fetch is served afterwards
    ram_lat  = 2;
    ram_hang = 1'b1;
    fork
      do_data(1'b0, OP_LW, 32'h2010, 32'h0, 1'b1);
      begin
        repeat (2) @(posedge clk);
        #1;
        do_fetch(32'h200, 1'b0);
      end
      begin
        int g;
        g = 0;
        n = 0;
        do begin
          @(negedge clk);
          n++;
          if (bus.mem_req) g++;
        end while (!bus.d_err && n < 60);
        ram_hang = 1'b0;
        check("t5_grant_cycles", 32'(g), 32'(TO));
        @(negedge clk);
        check("t5_req_drop", 32'(bus.mem_req), 32'h0);
        @(negedge clk);
        check("t5_fetch_req",  32'(bus.mem_req), 32'h1);
        check("t5_fetch_addr", bus.mem_addr, 32'h200);
      end
    join

    // reset during a fetch grant, late ack ignored
    @(posedge clk);
    #1;
    ram_hang   = 1'b1;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h300;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.mem_req && n < 10);
    check("t6_granted", 32'(bus.mem_req), 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.i_req = 1'b0;
    inj_req++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t6_mem_req", 32'(bus.mem_req), 32'h0);
      check("t6_i_ack",   32'(bus.i_ack), 32'h0);
      check("t6_i_err",   32'(bus.i_err), 32'h0);
    end
    ram_hang = 1'b0;

    // ack on the expiry cycle wins; one cycle later is a timeout
    @(posedge clk);
    #1;
    ram_lat = TO - 1;
    do_fetch(32'h304, 1'b0);
    do_data(1'b0, OP_LW, 32'h2014, 32'h0, 1'b0);
    ram_lat = TO;
    do_data(1'b0, OP_LW, 32'h2018, 32'h0, 1'b1);

    // random mixed traffic
    ram_rand = 1'b1;
    fork
      begin
        logic [31:0] fa;
        int gap;
        repeat (30) begin
          gap = int'($urandom_range(0, 3));
          repeat (gap) begin @(posedge clk); #1; end
          fa = 32'($urandom_range(0, 1023)) << 2;
          do_fetch(fa, 1'b0);
        end
      end
      begin
        logic [31:0] da;
        logic [31:0] wd;
        bit we;
        int gap;
        repeat (30) begin
          gap = int'($urandom_range(0, 3));
          repeat (gap) begin @(posedge clk); #1; end
          da = 32'h2000 + (32'($urandom_range(0, 15)) << 2);
          wd = $urandom;
          we = 1'($urandom_range(0, 1));
          do_data(we, we ? OP_SW : OP_LW, da, wd, 1'b0);
        end
      end
    join
    ram_rand = 1'b0;

    repeat (5) @(posedge clk);
    check("i_queue_empty", i_exp.size(), 32'd0);
    check("d_queue_empty", d_exp.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #400000;
    tests_run++;
    tests_failed++;
    $display("FAIL global_watchdog: simulation still running, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog expired");
  end
endmodule
